apb_master_arbiter: RTL and testbench
=====================================

# apb_master_arbiter

Round-robin arbiter and APB master sequencer that shares one APB master port between `REQ_COUNT` internal requesters (CPU bridge, DMA, debug, etc.). It sits directly upstream of `top_apb_demux` and drives its `psel_i`/`penable_i`/address/data inputs. It also returns read data and error status to the requester that owns the transfer. A programmable access timeout turns a hung slave into an error response instead of a bus lock.

## Interface
- `REQ_COUNT`, 4: number of requesters, ≥2.
- `APB_ADDR_WIDTH`, 32: address width.
- `APB_DATA_WIDTH`, 32: data width.
- `TIMEOUT_CYCLES`, 256: maximum ACCESS-phase cycles before forced abort; 0 disables the timeout.

Ports:
- `pclk_i` in 1: clock; all state changes on the rising edge.
- `presetn_i` in 1: reset, asynchronous, active-low.
- `req_i` in 1 [REQ_COUNT]: transfer request, held high until granted.
- `req_addr_i` in APB_ADDR_WIDTH [REQ_COUNT]: request address.
- `req_write_i` in 1 [REQ_COUNT]: 1 = write.
- `req_wdata_i` in APB_DATA_WIDTH [REQ_COUNT]: write data.
- `req_gnt_o` out 1 [REQ_COUNT]: grant; one-hot or zero; request fields are captured this cycle.
- `rsp_valid_o` out 1 [REQ_COUNT]: one-cycle completion pulse to the owning requester.
- `rsp_rdata_o` out APB_DATA_WIDTH: read data, valid with `rsp_valid_o`.
- `rsp_slverr_o` out 1: error status, valid with `rsp_valid_o`.
- `psel_o`, `penable_o`, `pwrite_o` out 1: APB master controls.
- `paddr_o` out APB_ADDR_WIDTH: APB address.
- `pwdata_o` out APB_DATA_WIDTH: APB write data.
- `prdata_i` in APB_DATA_WIDTH: APB read data.
- `pready_i`, `pslverr_i` in 1: APB slave response.

## Operation
- FSM states: IDLE, SETUP, ACCESS, DONE.
  - IDLE: any `req_i` set → grant winner, capture its addr/write/wdata, go to SETUP.
  - SETUP → ACCESS unconditionally.
  - ACCESS: `pready_i`=1 → capture `prdata_i` and `pslverr_i`, go to DONE. Timeout expiry → DONE with error.
  - DONE → IDLE.
- Arbitration (IDLE only):
  - Search `req_i` starting at round-robin pointer `rr_ptr`, ascending with wrap; the first set bit wins.
  - `req_gnt_o[w]` is asserted combinationally in that IDLE cycle.
  - On grant, `rr_ptr` ← (w+1) mod REQ_COUNT.
  - No grants outside IDLE.
- APB outputs:
  - `psel_o`=1 in SETUP and ACCESS.
  - `penable_o`=1 in ACCESS only.
  - `paddr_o`, `pwrite_o`, `pwdata_o` drive the captured registers; they are stable from SETUP through ACCESS and hold their value otherwise.
- Response:
  - In DONE, `rsp_valid_o[w]`=1 for one cycle.
  - `rsp_rdata_o` = captured `prdata_i` for reads, 0 for writes.
  - `rsp_slverr_o` = captured `pslverr_i`.
  - All response outputs are 0 outside DONE.
- Timeout:
  - Counter clears on entry to ACCESS and increments each ACCESS cycle with `pready_i`=0.
  - When `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES`-1 with `pready_i`=0, go to DONE with `rsp_slverr_o`=1 and `rsp_rdata_o`=0; `psel_o`/`penable_o` drop.
  - Counter width is $clog2(TIMEOUT_CYCLES+1).
- Boundary conditions:
  - `pready_i`=1 in the timeout-expiry cycle: a normal completion wins and `pslverr_i` is used.
  - A requester that drops `req_i` before grant is simply not granted; no response is issued.
  - A requester may hold `req_i` through its own transfer. It is re-granted only in a later IDLE and only per the round-robin order.
  - Single requester: back-to-back transfers every 4 cycles minimum.

## Timing
- Reset, asynchronous on `presetn_i`=0:
  - All outputs 0, including `paddr_o`/`pwdata_o`.
  - FSM goes to IDLE; `rr_ptr`=0; counter=0.
- Reset mid-transfer: `psel_o`/`penable_o` fall immediately, the transfer is lost, and no `rsp_valid_o` is issued.
- Latency with zero wait states, grant in cycle T:
  - SETUP at T+1, ACCESS at T+2 (`pready_i` sampled), DONE/`rsp_valid_o` at T+3, IDLE at T+4.
  - Each wait state adds one cycle.
- All outputs except `req_gnt_o` are registered or decoded from state only. `req_gnt_o` depends combinationally on `req_i` in IDLE.

## Test plan
- Single read: req 0, addr 0x1000_0004, slave returns `pready_i`=1 and 0xDEAD_BEEF in the first ACCESS cycle → `psel_o` high T+1..T+2, `penable_o` high T+2, `rsp_valid_o[0]` and rdata 0xDEAD_BEEF at T+3.
- Round robin: all 4 `req_i` held high from reset → grant order 0,1,2,3,0; exactly one transfer every 4 cycles; one `rsp_valid_o` pulse per grant.
- Wait states + write: req 2 writes 0x5A5A_5A5A, slave inserts 3 wait states → `paddr_o`/`pwdata_o` stable 4 ACCESS cycles, `rsp_valid_o[2]` one cycle later, `rsp_rdata_o`=0.
- Slave error: `pslverr_i`=1 with `pready_i` → `rsp_slverr_o`=1 in DONE only.
- Timeout: `TIMEOUT_CYCLES`=8, `pready_i` stuck at 0 → ACCESS lasts exactly 8 cycles, then DONE with slverr=1, rdata=0. Variant with `pready_i`=1 on cycle 8 → normal completion.
- Reset mid-ACCESS: assert `presetn_i`=0 during wait states → `psel_o`=`penable_o`=0 asynchronously, no response. After release, req 1 is granted first (`rr_ptr`=0, no req 0).

Source files
------------

// File: rtl/apb_master_arbiter.sv
// Round-robin arbiter sharing one APB master port between REQ_COUNT requesters.
// Captures the winning request, runs SETUP/ACCESS, returns the response to the
// owner, and aborts a hung ACCESS phase after TIMEOUT_CYCLES cycles.
module apb_master_arbiter #(
   parameter int unsigned REQ_COUNT      = 4,
   parameter int unsigned APB_ADDR_WIDTH = 32,
   parameter int unsigned APB_DATA_WIDTH = 32,
   parameter int unsigned TIMEOUT_CYCLES = 256
) (
   input  logic                      pclk_i,
   input  logic                      presetn_i,
   input  logic [REQ_COUNT-1:0]      req_i,
   input  logic [APB_ADDR_WIDTH-1:0] req_addr_i  [REQ_COUNT],
   input  logic [REQ_COUNT-1:0]      req_write_i,
   input  logic [APB_DATA_WIDTH-1:0] req_wdata_i [REQ_COUNT],
   output logic [REQ_COUNT-1:0]      req_gnt_o,
   output logic [REQ_COUNT-1:0]      rsp_valid_o,
   output logic [APB_DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                      rsp_slverr_o,
   output logic                      psel_o,
   output logic                      penable_o,
   output logic                      pwrite_o,
   output logic [APB_ADDR_WIDTH-1:0] paddr_o,
   output logic [APB_DATA_WIDTH-1:0] pwdata_o,
   input  logic [APB_DATA_WIDTH-1:0] prdata_i,
   input  logic                      pready_i,
   input  logic                      pslverr_i
);

   localparam int unsigned PW = $clog2(REQ_COUNT);
   // A disabled timeout still needs a 1-bit counter to keep the code legal.
   localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CW-1:0] TLAST = (TIMEOUT_CYCLES == 0) ? '0 : CW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

   state_e                    state_q, state_d;
   logic [PW-1:0]             rr_ptr_q, rr_ptr_d;
   logic [PW-1:0]             owner_q, owner_d;
   logic [APB_ADDR_WIDTH-1:0] addr_q, addr_d;
   logic                      write_q, write_d;
   logic [APB_DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [APB_DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                      slverr_q, slverr_d;
   logic [CW-1:0]             tcnt_q, tcnt_d;

   logic                      found;
   logic [PW-1:0]             win;
   logic [PW-1:0]             win_next;

   // Round-robin search starting at rr_ptr, ascending with wrap.
   always_comb begin
      int unsigned idx;
      int unsigned nxt;
      found = 1'b0;
      win   = '0;
      idx   = 0;
      for (int unsigned i = 0; i < REQ_COUNT; i++) begin
         idx = (32'(rr_ptr_q) + i) % REQ_COUNT;
         if (!found && req_i[PW'(idx)]) begin
            found = 1'b1;
            win   = PW'(idx);
         end
      end
      nxt      = (32'(win) + 1) % REQ_COUNT;
      win_next = PW'(nxt);
   end

   // Transfer sequencer: next state, captures, grant and timeout counter.
   always_comb begin
      state_d   = state_q;
      rr_ptr_d  = rr_ptr_q;
      owner_d   = owner_q;
      addr_d    = addr_q;
      write_d   = write_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      slverr_d  = slverr_q;
      tcnt_d    = tcnt_q;
      req_gnt_o = '0;
      case (state_q)
         IDLE: begin
            // Grant is masked while reset is held so no output toggles during reset.
            if (found && presetn_i) begin
               req_gnt_o[win] = 1'b1;
               owner_d        = win;
               addr_d         = req_addr_i[win];
               write_d        = req_write_i[win];
               wdata_d        = req_wdata_i[win];
               rr_ptr_d       = win_next;
               state_d        = SETUP;
            end
         end
         SETUP: begin
            tcnt_d  = '0;
            state_d = ACCESS;
         end
         ACCESS: begin
            if (pready_i) begin
               rdata_d  = write_q ? '0 : prdata_i;
               slverr_d = pslverr_i;
               state_d  = DONE;
            end else if (TIMEOUT_CYCLES != 0 && tcnt_q == TLAST) begin
               rdata_d  = '0;
               slverr_d = 1'b1;
               state_d  = DONE;
            end else begin
               tcnt_d = tcnt_q + CW'(1);
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // State and captured-field registers.
   always_ff @(posedge pclk_i or negedge presetn_i) begin
      if (!presetn_i) begin
         state_q  <= IDLE;
         rr_ptr_q <= '0;
         owner_q  <= '0;
         addr_q   <= '0;
         write_q  <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         slverr_q <= 1'b0;
         tcnt_q   <= '0;
      end else begin
         state_q  <= state_d;
         rr_ptr_q <= rr_ptr_d;
         owner_q  <= owner_d;
         addr_q   <= addr_d;
         write_q  <= write_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         slverr_q <= slverr_d;
         tcnt_q   <= tcnt_d;
      end
   end

   // APB and response outputs decoded from state and captured registers.
   always_comb begin
      psel_o       = (state_q == SETUP) || (state_q == ACCESS);
      penable_o    = (state_q == ACCESS);
      pwrite_o     = write_q;
      paddr_o      = addr_q;
      pwdata_o     = wdata_q;
      rsp_valid_o  = '0;
      rsp_rdata_o  = '0;
      rsp_slverr_o = 1'b0;
      if (state_q == DONE) begin
         rsp_valid_o[owner_q] = 1'b1;
         rsp_rdata_o          = rdata_q;
         rsp_slverr_o         = slverr_q;
      end
   end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// Self-checking bench for apb_master_arbiter with a 4-requester, 8-cycle-timeout build.
module tb_apb_master_arbiter;

   localparam int TO = 8;

   logic        clk;
   logic        presetn;
   logic [3:0]  req;
   logic [31:0] req_addr  [4];
   logic [3:0]  req_write;
   logic [31:0] req_wdata [4];
   logic [3:0]  gnt;
   logic [3:0]  rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_slverr;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata;
   logic        pready, pslverr;

   int errs;
   int checks;
   int exp_ptr;

   apb_master_arbiter #(
      .REQ_COUNT(4),
      .APB_ADDR_WIDTH(32),
      .APB_DATA_WIDTH(32),
      .TIMEOUT_CYCLES(TO)
   ) dut (
      .pclk_i(clk),
      .presetn_i(presetn),
      .req_i(req),
      .req_addr_i(req_addr),
      .req_write_i(req_write),
      .req_wdata_i(req_wdata),
      .req_gnt_o(gnt),
      .rsp_valid_o(rsp_valid),
      .rsp_rdata_o(rsp_rdata),
      .rsp_slverr_o(rsp_slverr),
      .psel_o(psel),
      .penable_o(penable),
      .pwrite_o(pwrite),
      .paddr_o(paddr),
      .pwdata_o(pwdata),
      .prdata_i(prdata),
      .pready_i(pready),
      .pslverr_i(pslverr)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic apply_reset();
      #2 presetn = 1'b0;
      tick();
      tick();
      presetn = 1'b1;
      exp_ptr = 0;
   endtask

   task automatic test_reset();
      req = 4'b1111;
      #2 presetn = 1'b0;
      #1;
      checks++;
      if ({gnt, rsp_valid, rsp_rdata, rsp_slverr, psel, penable, pwrite, paddr, pwdata} !== '0) begin
         errs++;
         $display("FAIL reset_outputs: gnt=%b rsp_valid=%b rdata=%h slverr=%b psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h required all 0",
                  gnt, rsp_valid, rsp_rdata, rsp_slverr, psel, penable, pwrite, paddr, pwdata);
      end
      tick();
      tick();
      req = 4'b0000;
      presetn = 1'b1;
      exp_ptr = 0;
      #1;
      checks++;
      if (gnt !== 4'b0000 || psel !== 1'b0) begin
         errs++;
         $display("FAIL reset_idle: gnt=%b psel=%b required 0000/0", gnt, psel);
      end
   endtask

   task automatic test_single_read();
      req_addr[0] = 32'h1000_0004;
      req_write[0] = 1'b0;
      req = 4'b0001;
      #1;
      checks++;
      if (gnt !== 4'b0001 || psel !== 1'b0) begin
         errs++;
         $display("FAIL read_grant: gnt=%b psel=%b required 0001/0", gnt, psel);
      end
      tick();
      req = 4'b0000;
      pready = 1'b1;
      prdata = 32'hDEAD_BEEF;
      checks++;
      if (psel !== 1'b1 || penable !== 1'b0 || paddr !== 32'h1000_0004 || pwrite !== 1'b0) begin
         errs++;
         $display("FAIL read_setup: psel=%b penable=%b paddr=%h pwrite=%b required 1/0/10000004/0", psel, penable, paddr, pwrite);
      end
      tick();
      checks++;
      if (psel !== 1'b1 || penable !== 1'b1 || rsp_valid !== 4'b0000) begin
         errs++;
         $display("FAIL read_access: psel=%b penable=%b rsp_valid=%b required 1/1/0000", psel, penable, rsp_valid);
      end
      tick();
      pready = 1'b0;
      checks++;
      if (rsp_valid !== 4'b0001 || rsp_rdata !== 32'hDEAD_BEEF || rsp_slverr !== 1'b0 || psel !== 1'b0) begin
         errs++;
         $display("FAIL read_done: rsp_valid=%b rdata=%h slverr=%b psel=%b required 0001/deadbeef/0/0", rsp_valid, rsp_rdata, rsp_slverr, psel);
      end
      tick();
      checks++;
      if (rsp_valid !== 4'b0000 || rsp_rdata !== 32'h0) begin
         errs++;
         $display("FAIL read_after: rsp_valid=%b rdata=%h required 0000/0", rsp_valid, rsp_rdata);
      end
      exp_ptr = 1;
   endtask

   task automatic test_round_robin();
      logic [3:0] exp;
      req = 4'b1111;
      apply_reset();
      pready = 1'b1;
      pslverr = 1'b0;
      for (int k = 0; k < 5; k++) begin
         exp = 4'b0001 << (k % 4);
         #1;
         checks++;
         if (gnt !== exp) begin
            errs++;
            $display("FAIL rr_grant[%0d]: gnt=%b required %b", k, gnt, exp);
         end
         tick();
         checks++;
         if (gnt !== 4'b0000 || rsp_valid !== 4'b0000) begin
            errs++;
            $display("FAIL rr_nogrant[%0d]: gnt=%b rsp_valid=%b required 0000/0000", k, gnt, rsp_valid);
         end
         tick();
         tick();
         checks++;
         if (rsp_valid !== exp) begin
            errs++;
            $display("FAIL rr_rsp[%0d]: rsp_valid=%b required %b", k, rsp_valid, exp);
         end
         tick();
      end
      req = 4'b0000;
      pready = 1'b0;
      exp_ptr = 1;
   endtask

   task automatic test_wait_write();
      int acc;
      logic [31:0] a;
      a = $urandom;
      req_addr[2] = a;
      req_wdata[2] = 32'h5A5A_5A5A;
      req_write[2] = 1'b1;
      req = 4'b0100;
      #1;
      checks++;
      if (gnt !== 4'b0100) begin
         errs++;
         $display("FAIL ww_grant: gnt=%b required 0100", gnt);
      end
      tick();
      req = 4'b0000;
      prdata = 32'h1234_5678;
      tick();
      acc = 0;
      while (penable === 1'b1 && acc < 20) begin
         acc++;
         checks++;
         if (paddr !== a || pwdata !== 32'h5A5A_5A5A || pwrite !== 1'b1 || psel !== 1'b1) begin
            errs++;
            $display("FAIL ww_stable[%0d]: paddr=%h pwdata=%h pwrite=%b psel=%b required %h/5a5a5a5a/1/1", acc, paddr, pwdata, pwrite, psel, a);
         end
         pready = (acc == 4);
         tick();
      end
      pready = 1'b0;
      checks++;
      if (acc !== 4) begin
         errs++;
         $display("FAIL ww_access_len: got %0d cycles required 4", acc);
      end
      checks++;
      if (rsp_valid !== 4'b0100 || rsp_rdata !== 32'h0 || rsp_slverr !== 1'b0) begin
         errs++;
         $display("FAIL ww_done: rsp_valid=%b rdata=%h slverr=%b required 0100/0/0", rsp_valid, rsp_rdata, rsp_slverr);
      end
      tick();
      exp_ptr = 3;
   endtask

   task automatic test_slverr();
      req_addr[1] = $urandom;
      req_write[1] = 1'b0;
      req = 4'b0010;
      pslverr = 1'b1;
      tick();
      req = 4'b0000;
      checks++;
      if (rsp_slverr !== 1'b0 || psel !== 1'b1) begin
         errs++;
         $display("FAIL err_setup: slverr=%b psel=%b required 0/1", rsp_slverr, psel);
      end
      pready = 1'b1;
      tick();
      checks++;
      if (rsp_slverr !== 1'b0) begin
         errs++;
         $display("FAIL err_access: slverr=%b required 0", rsp_slverr);
      end
      tick();
      pready = 1'b0;
      checks++;
      if (rsp_valid !== 4'b0010 || rsp_slverr !== 1'b1) begin
         errs++;
         $display("FAIL err_done: rsp_valid=%b slverr=%b required 0010/1", rsp_valid, rsp_slverr);
      end
      tick();
      checks++;
      if (rsp_slverr !== 1'b0) begin
         errs++;
         $display("FAIL err_after: slverr=%b required 0", rsp_slverr);
      end
      pslverr = 1'b0;
      exp_ptr = 2;
   endtask

   task automatic test_timeout(input bit ready_last);
      int acc;
      req_addr[0] = $urandom;
      req_write[0] = 1'b0;
      req = 4'b0001;
      prdata = 32'hCAFE_0001;
      pslverr = 1'b0;
      tick();
      req = 4'b0000;
      tick();
      acc = 0;
      while (penable === 1'b1 && acc < 20) begin
         acc++;
         pready = ready_last && (acc == TO);
         tick();
      end
      pready = 1'b0;
      checks++;
      if (acc !== TO) begin
         errs++;
         $display("FAIL to_len[%0d]: got %0d access cycles required %0d", ready_last, acc, TO);
      end
      checks++;
      if (ready_last) begin
         if (rsp_valid !== 4'b0001 || rsp_slverr !== 1'b0 || rsp_rdata !== 32'hCAFE_0001 || psel !== 1'b0) begin
            errs++;
            $display("FAIL to_ready_last: rsp_valid=%b slverr=%b rdata=%h psel=%b required 0001/0/cafe0001/0", rsp_valid, rsp_slverr, rsp_rdata, psel);
         end
      end else begin
         if (rsp_valid !== 4'b0001 || rsp_slverr !== 1'b1 || rsp_rdata !== 32'h0 || psel !== 1'b0 || penable !== 1'b0) begin
            errs++;
            $display("FAIL to_expire: rsp_valid=%b slverr=%b rdata=%h psel=%b penable=%b required 0001/1/0/0/0", rsp_valid, rsp_slverr, rsp_rdata, psel, penable);
         end
      end
      tick();
      exp_ptr = 1;
   endtask

   task automatic test_reset_mid_access();
      int seen;
      req_addr[3] = $urandom;
      req_write[3] = 1'b0;
      req = 4'b1000;
      tick();
      req = 4'b0000;
      tick();
      tick();
      #2 presetn = 1'b0;
      #1;
      checks++;
      if (psel !== 1'b0 || penable !== 1'b0 || paddr !== 32'h0) begin
         errs++;
         $display("FAIL rst_mid: psel=%b penable=%b paddr=%h required 0/0/0", psel, penable, paddr);
      end
      tick();
      presetn = 1'b1;
      exp_ptr = 0;
      seen = 0;
      for (int c = 0; c < 4; c++) begin
         if (rsp_valid !== 4'b0000) seen++;
         tick();
      end
      checks++;
      if (seen !== 0) begin
         errs++;
         $display("FAIL rst_no_rsp: got %0d response cycles required 0", seen);
      end
      req = 4'b1110;
      #1;
      checks++;
      if (gnt !== 4'b0010) begin
         errs++;
         $display("FAIL rst_first_grant: gnt=%b required 0010", gnt);
      end
      tick();
      req = 4'b0000;
      pready = 1'b1;
      tick();
      tick();
      pready = 1'b0;
      tick();
      exp_ptr = 2;
   endtask

   task automatic test_random();
      logic [3:0]  mask;
      logic [3:0]  exp;
      logic [31:0] rd;
      logic        er;
      logic        exp_to;
      int          w, waits, acc, exp_acc;
      for (int t = 0; t < 40; t++) begin
         mask = 4'($urandom_range(1, 15));
         for (int r = 0; r < 4; r++) begin
            req_addr[r]  = $urandom;
            req_wdata[r] = $urandom;
            req_write[r] = 1'($urandom_range(0, 1));
         end
         req = mask;
         w = -1;
         for (int k = 0; k < 4; k++)
            if (w < 0 && mask[(exp_ptr + k) % 4]) w = (exp_ptr + k) % 4;
         exp = 4'b0001 << w;
         exp_ptr = (w + 1) % 4;
         #1;
         checks++;
         if (gnt !== exp) begin
            errs++;
            $display("FAIL rnd_grant[%0d]: gnt=%b required %b (req=%b)", t, gnt, exp, mask);
         end
         tick();
         checks++;
         if (gnt !== 4'b0000 || psel !== 1'b1 || penable !== 1'b0 || pwrite !== req_write[w] ||
             paddr !== req_addr[w] || pwdata !== req_wdata[w]) begin
            errs++;
            $display("FAIL rnd_setup[%0d]: gnt=%b psel=%b penable=%b pwrite=%b paddr=%h pwdata=%h required 0000/1/0/%b/%h/%h",
                     t, gnt, psel, penable, pwrite, paddr, pwdata, req_write[w], req_addr[w], req_wdata[w]);
         end
         waits = $urandom_range(0, 10);
         rd    = $urandom;
         er    = 1'($urandom_range(0, 1));
         tick();
         acc = 0;
         while (penable === 1'b1 && acc < 20) begin
            acc++;
            pready  = (acc == waits + 1);
            prdata  = rd;
            pslverr = er;
            tick();
         end
         pready  = 1'b0;
         pslverr = 1'b0;
         exp_to  = (waits >= TO);
         exp_acc = exp_to ? TO : waits + 1;
         checks++;
         if (acc !== exp_acc) begin
            errs++;
            $display("FAIL rnd_len[%0d]: got %0d access cycles required %0d", t, acc, exp_acc);
         end
         checks++;
         if (rsp_valid !== exp || rsp_rdata !== ((exp_to || req_write[w]) ? 32'h0 : rd) ||
             rsp_slverr !== (exp_to ? 1'b1 : er)) begin
            errs++;
            $display("FAIL rnd_rsp[%0d]: rsp_valid=%b rdata=%h slverr=%b required %b/%h/%b", t, rsp_valid, rsp_rdata, rsp_slverr,
                     exp, ((exp_to || req_write[w]) ? 32'h0 : rd), (exp_to ? 1'b1 : er));
         end
         req = 4'b0000;
         tick();
         checks++;
         if (rsp_valid !== 4'b0000 || psel !== 1'b0) begin
            errs++;
            $display("FAIL rnd_idle[%0d]: rsp_valid=%b psel=%b required 0000/0", t, rsp_valid, psel);
         end
      end
   endtask

   initial begin
      errs = 0;
      checks = 0;
      exp_ptr = 0;
      presetn = 1'b1;
      req = 4'b0000;
      req_write = 4'b0000;
      for (int r = 0; r < 4; r++) begin
         req_addr[r]  = 32'h0;
         req_wdata[r] = 32'h0;
      end
      prdata = 32'h0;
      pready = 1'b0;
      pslverr = 1'b0;
      tick();
      test_reset();
      test_single_read();
      test_round_robin();
      test_wait_write();
      test_slverr();
      test_timeout(1'b0);
      test_timeout(1'b1);
      test_reset_mid_access();
      test_random();
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end

endmodule
